// File: rtl/reg_ctx_engine_if.sv
// Register-file and data-memory bus bundle for the context engine.
// master: the engine (drives rf read/write addresses and the memory request).
// slave : the register file / memory arbiter side.
//   rf_read_addr/rf_read_data         combinational register-file read port
//   rf_write_en/addr/data             register-file write port
//   mem_req/we/addr/wdata             memory request, held until mem_ack
//   mem_rdata/mem_ack                 memory response, valid in the ack cycle
interface reg_ctx_engine_if #(
    parameter int unsigned RA_W   = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned MEM_AW = 8
);
    logic [RA_W-1:0]   rf_read_addr;
    logic [DATA_W-1:0] rf_read_data;
    logic              rf_write_en;
    logic [RA_W-1:0]   rf_write_addr;
    logic [DATA_W-1:0] rf_write_data;
    logic              mem_req;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output rf_read_addr,
        input  rf_read_data,
        output rf_write_en, rf_write_addr, rf_write_data,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  rf_read_addr,
        output rf_read_data,
        input  rf_write_en, rf_write_addr, rf_write_data,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/reg_ctx_engine.sv
// Context save/restore sequencer. start_save copies every register-file entry
// to data memory at base_addr; start_restore copies them back.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start_save, start_restore  single-cycle requests, accepted only in IDLE
//   base_addr                  context area base, sampled on an accepted start
//   busy, done, ctx_err        status (done is a one-cycle pulse)
//   bus                        register-file / memory bus (master side)
// Optional feature: define CTX_CHECKSUM_EN to append an XOR checksum word at
// base+NUM_REGS on save and verify it on restore (ctx_err reports mismatch).
module reg_ctx_engine #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned RA_W     = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MEM_AW   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_save,
    input  logic              start_restore,
    input  logic [MEM_AW-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              ctx_err,
    reg_ctx_engine_if.master  bus
);
    // One extra index value addresses the checksum word.
    localparam int unsigned IDX_W = RA_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
`ifdef CTX_CHECKSUM_EN
    localparam logic [IDX_W-1:0] CSUM_IDX = IDX_W'(NUM_REGS);
`endif

    typedef enum logic [2:0] {S_IDLE, S_SAVE, S_LOAD, S_WRITE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [MEM_AW-1:0] base_q, base_d;
    logic [DATA_W-1:0] rdat_q, rdat_d;
    logic [MEM_AW-1:0] addr_c;
`ifdef CTX_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
    logic              err_q, err_d;
`endif

    // Memory address wraps modulo 2**MEM_AW by construction.
    assign addr_c = base_q + MEM_AW'(idx_q);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            base_q  <= '0;
            rdat_q  <= '0;
`ifdef CTX_CHECKSUM_EN
            csum_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            rdat_q  <= rdat_d;
`ifdef CTX_CHECKSUM_EN
            csum_q  <= csum_d;
            err_q   <= err_d;
`endif
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        rdat_d  = rdat_q;
`ifdef CTX_CHECKSUM_EN
        csum_d  = csum_q;
        err_d   = err_q;
        ctx_err = err_q;
`else
        ctx_err = 1'b0;
`endif
        busy              = (state_q != S_IDLE);
        done              = 1'b0;
        bus.rf_read_addr  = '0;
        bus.rf_write_en   = 1'b0;
        bus.rf_write_addr = '0;
        bus.rf_write_data = '0;
        bus.mem_req       = 1'b0;
        bus.mem_we        = 1'b0;
        bus.mem_addr      = '0;
        bus.mem_wdata     = '0;

        case (state_q)
            S_IDLE: begin
                if (start_save || start_restore) begin
                    base_d  = base_addr;
                    idx_d   = '0;
                    state_d = start_save ? S_SAVE : S_LOAD;
`ifdef CTX_CHECKSUM_EN
                    csum_d  = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            S_SAVE: begin
                bus.mem_req      = 1'b1;
                bus.mem_we       = 1'b1;
                bus.mem_addr     = addr_c;
                bus.rf_read_addr = RA_W'(idx_q);
                bus.mem_wdata    = bus.rf_read_data;
`ifdef CTX_CHECKSUM_EN
                if (idx_q == CSUM_IDX) begin
                    bus.rf_read_addr = '0;
                    bus.mem_wdata    = csum_q;
                end
                if (bus.mem_ack) begin
                    if (idx_q == CSUM_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        csum_d = csum_q ^ bus.rf_read_data;
                        idx_d  = idx_q + 1'b1;
                    end
                end
`else
                if (bus.mem_ack) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
`endif
            end
            S_LOAD: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = addr_c;
                if (bus.mem_ack) begin
`ifdef CTX_CHECKSUM_EN
                    if (idx_q == CSUM_IDX) begin
                        err_d   = (bus.mem_rdata != csum_q);
                        state_d = S_DONE;
                    end else begin
                        csum_d  = csum_q ^ bus.mem_rdata;
                        rdat_d  = bus.mem_rdata;
                        state_d = S_WRITE;
                    end
`else
                    rdat_d  = bus.mem_rdata;
                    state_d = S_WRITE;
`endif
                end
            end
            S_WRITE: begin
                bus.rf_write_en   = 1'b1;
                bus.rf_write_addr = RA_W'(idx_q);
                bus.rf_write_data = rdat_q;
                idx_d             = idx_q + 1'b1;
                state_d           = S_LOAD;
`ifndef CTX_CHECKSUM_EN
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                end
`endif
            end
            S_DONE: begin
                done    = 1'b1;
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_reg_ctx_engine.sv
// Self-checking bench for reg_ctx_engine: register-file and memory models,
// expected-transfer queues filled when an operation is started, drained by
// negedge monitors as the DUT performs transfers.
module tb_reg_ctx_engine;
    localparam int unsigned N      = 16;
    localparam int unsigned RA_W   = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned MEM_AW = 8;
`ifdef CTX_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start_save;
    logic       start_restore;
    logic [7:0] base_addr;
    logic       busy, done, ctx_err;

    always #5 clk = ~clk;

    reg_ctx_engine_if #(.RA_W(RA_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW)) bus_if ();

    reg_ctx_engine #(.NUM_REGS(N), .RA_W(RA_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_save   (start_save),
        .start_restore(start_restore),
        .base_addr    (base_addr),
        .busy         (busy),
        .done         (done),
        .ctx_err      (ctx_err),
        .bus          (bus_if)
    );

    // Register-file and memory models.
    logic [7:0] rf_m  [0:15];
    logic [7:0] mem_m [0:255];
    int         ack_lat  = 0;
    int         wait_cnt = 0;
    int         cmd      = 0;
    logic [7:0] arg_a    = '0;
    logic [7:0] arg_b    = '0;
    logic [7:0] arg_s    = '0;

    assign bus_if.rf_read_data = rf_m[bus_if.rf_read_addr];
    assign bus_if.mem_rdata    = mem_m[bus_if.mem_addr];
    assign bus_if.mem_ack      = bus_if.mem_req && (wait_cnt >= ack_lat);

    always @(posedge clk) begin
        if (cmd == 1) for (int i = 0; i < 16; i++) rf_m[i] <= arg_a + 8'(i) * arg_s;
        else if (cmd == 2) for (int i = 0; i < 16; i++) mem_m[8'(arg_a + 8'(i))] <= arg_b + 8'(i);
        else if (cmd == 3) mem_m[arg_a] <= arg_b;
        if (bus_if.rf_write_en) rf_m[bus_if.rf_write_addr] <= bus_if.rf_write_data;
        if (!reset && bus_if.mem_req && bus_if.mem_ack && bus_if.mem_we)
            mem_m[bus_if.mem_addr] <= bus_if.mem_wdata;
        if (!reset && bus_if.mem_req && !bus_if.mem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } mem_exp_t;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } rf_exp_t;

    mem_exp_t mem_q[$];
    rf_exp_t  rf_q[$];
    int       n_chk = 0;
    int       n_fail = 0;
    bit       sb_mem_en = 1'b1;
    int       busy_cnt = 0, done_cnt = 0, mem_xfer_cnt = 0, rf_wr_cnt = 0;
    logic     done_err = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Transfer monitors.
    always @(negedge clk) begin
        if (!reset) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_err = ctx_err;
            end
            if (bus_if.mem_req && bus_if.mem_ack) begin
                mem_xfer_cnt++;
                if (sb_mem_en) begin
                    check_eq("mem_expected_pending", 32'(mem_q.size() != 0), 1);
                    if (mem_q.size() != 0) begin
                        mem_exp_t e;
                        e = mem_q.pop_front();
                        check_eq("mem_addr", 32'(bus_if.mem_addr), 32'(e.addr));
                        check_eq("mem_we", 32'(bus_if.mem_we), 32'(e.we));
                        if (e.we) check_eq("mem_wdata", 32'(bus_if.mem_wdata), 32'(e.data));
                    end
                end
            end
            if (bus_if.rf_write_en) begin
                rf_wr_cnt++;
                check_eq("rf_expected_pending", 32'(rf_q.size() != 0), 1);
                if (rf_q.size() != 0) begin
                    rf_exp_t r;
                    r = rf_q.pop_front();
                    check_eq("rf_write_addr", 32'(bus_if.rf_write_addr), 32'(r.addr));
                    check_eq("rf_write_data", 32'(bus_if.rf_write_data), 32'(r.data));
                end
            end
        end
    end

    task automatic model_cmd(input int c, input logic [7:0] a, input logic [7:0] b, input logic [7:0] s);
        @(negedge clk);
        cmd = c; arg_a = a; arg_b = b; arg_s = s;
        @(negedge clk);
        cmd = 0;
    endtask

    task automatic push_save(input logic [7:0] base, input logic [7:0] seed);
        logic [7:0] cs;
        cs = '0;
        for (int i = 0; i < 16; i++) begin
            mem_q.push_back('{we: 1'b1, addr: 8'(base + 8'(i)), data: 8'(seed + 8'(i))});
            cs = cs ^ 8'(seed + 8'(i));
        end
        if (CS != 0) mem_q.push_back('{we: 1'b1, addr: 8'(base + 8'(16)), data: cs});
    endtask

    task automatic push_restore(input logic [7:0] base, input logic [7:0] seed);
        for (int i = 0; i < 16; i++) begin
            mem_q.push_back('{we: 1'b0, addr: 8'(base + 8'(i)), data: 8'h00});
            rf_q.push_back('{addr: 4'(i), data: 8'(seed + 8'(i))});
        end
        if (CS != 0) mem_q.push_back('{we: 1'b0, addr: 8'(base + 8'(16)), data: 8'h00});
    endtask

    task automatic clear_counts();
        busy_cnt = 0; done_cnt = 0; mem_xfer_cnt = 0; rf_wr_cnt = 0; done_err = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            #1;
            if (!busy) return;
        end
        check_eq({tag, "_idle_timeout"}, 32'(busy), 0);
    endtask

    task automatic run_op(input bit sv, input bit rs, input logic [7:0] base,
                          input int exp_busy, input string tag);
        clear_counts();
        @(negedge clk);
        start_save = sv; start_restore = rs; base_addr = base;
        @(negedge clk);
        start_save = 1'b0; start_restore = 1'b0; base_addr = 8'h00;
        wait_idle(tag);
        check_eq({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
        check_eq({tag, "_done_pulses"}, 32'(done_cnt), 1);
        check_eq({tag, "_mem_left"}, 32'(mem_q.size()), 0);
        check_eq({tag, "_rf_left"}, 32'(rf_q.size()), 0);
    endtask

    initial begin
        reset = 1'b1; start_save = 1'b0; start_restore = 1'b0; base_addr = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_ctx_err", 32'(ctx_err), 0);
        check_eq("rst_mem_req", 32'(bus_if.mem_req), 0);
        check_eq("rst_mem_we", 32'(bus_if.mem_we), 0);
        check_eq("rst_mem_addr", 32'(bus_if.mem_addr), 0);
        check_eq("rst_mem_wdata", 32'(bus_if.mem_wdata), 0);
        check_eq("rst_rf_we", 32'(bus_if.rf_write_en), 0);
        check_eq("rst_rf_waddr", 32'(bus_if.rf_write_addr), 0);
        check_eq("rst_rf_wdata", 32'(bus_if.rf_write_data), 0);
        check_eq("rst_rf_raddr", 32'(bus_if.rf_read_addr), 0);
        reset = 1'b0;

        // Save 8'h10+i to 8'h40, zero-wait memory.
        model_cmd(1, 8'h10, 8'h00, 8'h01);
        push_save(8'h40, 8'h10);
        run_op(1'b1, 1'b0, 8'h40, N + CS + 1, "save1");
        for (int i = 0; i < 16; i++) check_eq("save1_mem", 32'(mem_m[8'h40 + i]), 32'(8'h10 + i));

        // Restore 8'hA0+i from 8'h80 with two wait cycles per read.
        model_cmd(2, 8'h80, 8'hA0, 8'h00);
        model_cmd(1, 8'h00, 8'h00, 8'h00);
        ack_lat = 2;
        push_restore(8'h80, 8'hA0);
        run_op(1'b0, 1'b1, 8'h80, N * 4 + CS * 3 + 1, "restore2");
        ack_lat = 0;
        check_eq("restore2_rf_writes", 32'(rf_wr_cnt), 16);
        check_eq("restore2_ctx_err", 32'(done_err), 0);
        for (int i = 0; i < 16; i++) check_eq("restore2_rf", 32'(rf_m[i]), 32'(8'hA0 + i));

        // Simultaneous starts: save wins; a restore pulse while busy is ignored.
        model_cmd(1, 8'h60, 8'h00, 8'h01);
        push_save(8'h20, 8'h60);
        clear_counts();
        @(negedge clk);
        start_save = 1'b1; start_restore = 1'b1; base_addr = 8'h20;
        @(negedge clk);
        start_save = 1'b0; start_restore = 1'b0; base_addr = 8'h00;
        repeat (3) @(negedge clk);
        start_restore = 1'b1;
        @(negedge clk);
        start_restore = 1'b0;
        wait_idle("both");
        check_eq("both_busy_cycles", 32'(busy_cnt), 32'(N + CS + 1));
        check_eq("both_done_pulses", 32'(done_cnt), 1);
        check_eq("both_mem_left", 32'(mem_q.size()), 0);
        check_eq("both_rf_writes", 32'(rf_wr_cnt), 0);
        repeat (4) @(posedge clk);
        #1;
        check_eq("both_stays_idle", 32'(busy), 0);

        // Address wrap from base 8'hF8.
        model_cmd(1, 8'h70, 8'h00, 8'h01);
        push_save(8'hF8, 8'h70);
        run_op(1'b1, 1'b0, 8'hF8, N + CS + 1, "wrap4");
        check_eq("wrap4_mem_ff", 32'(mem_m[8'hFF]), 32'h77);
        check_eq("wrap4_mem_00", 32'(mem_m[8'h00]), 32'h78);
        check_eq("wrap4_mem_07", 32'(mem_m[8'h07]), 32'h7F);

        // Reset after the 5th restore write.
        model_cmd(1, 8'h55, 8'h00, 8'h00);
        sb_mem_en = 1'b0;
        for (int i = 0; i < 5; i++) rf_q.push_back('{addr: 4'(i), data: 8'(8'hA0 + 8'(i))});
        clear_counts();
        @(negedge clk);
        start_restore = 1'b1; base_addr = 8'h80;
        @(negedge clk);
        start_restore = 1'b0; base_addr = 8'h00;
        for (int k = 0; k < 200 && rf_wr_cnt < 5; k++) begin
            @(posedge clk);
            #1;
        end
        check_eq("rst5_reached_5", 32'(rf_wr_cnt), 5);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst5_busy", 32'(busy), 0);
        check_eq("rst5_mem_req", 32'(bus_if.mem_req), 0);
        check_eq("rst5_rf_we", 32'(bus_if.rf_write_en), 0);
        check_eq("rst5_done", 32'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("rst5_rf_writes", 32'(rf_wr_cnt), 5);
        check_eq("rst5_busy_after", 32'(busy), 0);
        for (int i = 0; i < 16; i++)
            check_eq("rst5_rf", 32'(rf_m[i]), (i < 5) ? 32'(8'hA0 + i) : 32'h55);
        sb_mem_en = 1'b1;

`ifdef CTX_CHECKSUM_EN
        // Checksum: corrupted restore flags ctx_err, clean restore does not.
        model_cmd(1, 8'h30, 8'h00, 8'h01);
        push_save(8'h40, 8'h30);
        run_op(1'b1, 1'b0, 8'h40, N + 2, "cs_save");
        model_cmd(3, 8'h43, 8'hCC, 8'h00);
        push_restore(8'h40, 8'h30);
        rf_q[3].data = 8'hCC;
        run_op(1'b0, 1'b1, 8'h40, 2 * N + 2, "cs_bad");
        check_eq("cs_bad_err_at_done", 32'(done_err), 1);
        check_eq("cs_bad_err_held", 32'(ctx_err), 1);
        check_eq("cs_bad_xfers", 32'(mem_xfer_cnt), 17);
        model_cmd(3, 8'h43, 8'h33, 8'h00);
        push_restore(8'h40, 8'h30);
        run_op(1'b0, 1'b1, 8'h40, 2 * N + 2, "cs_good");
        check_eq("cs_good_err_at_done", 32'(done_err), 0);
        check_eq("cs_good_err_after", 32'(ctx_err), 0);
        check_eq("cs_good_xfers", 32'(mem_xfer_cnt), 17);
`else
        check_eq("nocs_ctx_err", 32'(ctx_err), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
